stream_arb2x128: RTL and testbench
==================================

Name: stream_arb2x128

Overview:
Round-robin arbiter that merges two 128-bit host-to-card input streams onto one 128-bit output stream. Each input is a valid/rdy stream.
- It sits between the stream input interfaces and a single shared kernel input, for example a loopback or checksum kernel.
- A grant is held for a bounded burst so one source cannot starve the other.
- It keeps per-source accepted-beat counters for host status readback.

Parameters:
MAX_BURST, 16, max beats per grant before forced rotation; legal range 1..255
CNT_W, 32, width of per-source beat counters

Ports:
clk  input  1  stream clock, shared by all streams
rst  input  1  synchronous active-high reset
s1i_valid  input  1  stream 1 in: data valid
s1i_rdy  output  1  stream 1 in: arbiter accepts data
s1i_data  input  128  stream 1 in: data
s2i_valid  input  1  stream 2 in: data valid
s2i_rdy  output  1  stream 2 in: arbiter accepts data
s2i_data  input  128  stream 2 in: data
s1o_valid  output  1  merged out: data valid (registered)
s1o_rdy  input  1  merged out: downstream ready
s1o_data  output  128  merged out: data (registered)
beats1  output  CNT_W  stream 1 beats accepted (registered)
beats2  output  CNT_W  stream 2 beats accepted (registered)

Behaviour:
- Reset values:
  - state=IDLE, last=S2 (so S1 wins the first tie), burst counter=0.
  - s1o_valid=0, s1o_data=0, beats1=beats2=0.
  - s1i_rdy and s2i_rdy are 0 while state=IDLE.
- Reset mid-burst: the in-flight output beat is dropped and all state returns to the reset values on the next edge.
- adv = ~s1o_valid | s1o_rdy (the output register can load).
- siX_rdy = adv & (state==GX). Both ready signals are combinational; at most one is ever 1.
- A transfer on source X is siX_valid & siX_rdy. On a transfer:
  - s1o_data <= siX_data and s1o_valid <= 1.
  - beatsX increments, wrapping modulo 2^CNT_W.
  - The burst counter increments.
- If adv is true and no transfer occurs: s1o_valid <= 0.
- If adv is false: s1o_valid and s1o_data hold.
- States: IDLE, G1, G2.
- IDLE:
  - Both valid: grant the source not equal to last.
  - Only one valid: grant that source.
  - Neither valid: stay in IDLE.
  - No transfer happens in IDLE, so there is a 1-cycle arbitration bubble.
- GX, burst exit: a transfer with burst counter == MAX_BURST-1.
  - The other source valid: switch directly to the other grant (no bubble).
  - Otherwise go to IDLE.
- GX, source drained: siX_valid=0 and no transfer.
  - The other source valid: switch to it.
  - Otherwise go to IDLE.
- GX stalled: siX_valid=1 with adv=0 holds the grant; no counts change.
- On every grant exit: last <= X and the burst counter <= 0.
- Latency: 2 cycles from siX_valid rising in IDLE to s1o_valid. Throughput is 1 beat/cycle within a grant and across a direct switch.
- MAX_BURST=1: the grant alternates every beat when both sources are valid.
- Data ordering within each source is preserved. No beat is duplicated or lost.

Optional Feature:
STREAM_ARB_TAG_EN:
- Defined: s1o_data[127:120] is replaced by the source ID, 8'h01 for S1 and 8'h02 for S2. Bits [119:0] pass through unchanged.
- Undefined: all 128 bits pass through unmodified. Tag logic is absent.

Test Plan:
1. Single source, no backpressure:
   - Stimulus: only s1i_valid, data 1,2,3,4, s1o_rdy=1.
   - Response: s1o_data 1,2,3,4 on consecutive cycles; first s1o_valid 2 cycles after s1i_valid; beats1=4, beats2=0.
2. Both sources always valid, MAX_BURST=4:
   - Stimulus: s1o_rdy=1.
   - Response: output is 4 S1 beats then 4 S2 beats, repeating; no invalid cycle at switches; after 16 outputs beats1=beats2=8.
3. Output backpressure:
   - Stimulus: s1o_valid=1 with data 0xA5, then s1o_rdy=0 for 5 cycles.
   - Response: s1o_data holds 0xA5; s1i_rdy=s2i_rdy=0; beat counters and burst counter unchanged; the next beat appears on the cycle after s1o_rdy returns to 1.
4. Early drain:
   - Stimulus: S1 sends 2 beats then drops valid; s2i_valid is held high.
   - Response: G2 is granted the next cycle; S2 then gets a full MAX_BURST beats before rotation.
5. Reset mid-burst:
   - Stimulus: rst=1 for one cycle during a G1 burst with s1o_valid=1.
   - Response: next cycle s1o_valid=0, beats1=beats2=0, s1i_rdy=0; S1 wins the next tie.
6. Tagging (STREAM_ARB_TAG_EN defined):
   - Stimulus: S2 data 128'hFF..FF.
   - Response: s1o_data=128'h02FF..FF.
   - With the macro undefined: output is 128'hFF..FF.

Source files
------------

// File: rtl/stream_arb2x128.sv
// stream_arb2x128: round-robin merge of two 128-bit valid/rdy streams with bounded bursts and per-source beat counters.
// Optional feature macro STREAM_ARB_TAG_EN: when defined, s1o_data[127:120] carries the source ID (8'h01 / 8'h02).
module stream_arb2x128 #(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s1i_valid,
  output logic             s1i_rdy,
  input  logic [127:0]     s1i_data,
  input  logic             s2i_valid,
  output logic             s2i_rdy,
  input  logic [127:0]     s2i_data,
  output logic             s1o_valid,
  input  logic             s1o_rdy,
  output logic [127:0]     s1o_data,
  output logic [CNT_W-1:0] beats1,
  output logic [CNT_W-1:0] beats2
);
  typedef enum logic [1:0] {IDLE, G1, G2} state_t;
  state_t           r_state, w_next;
  logic             r_last;
  logic [7:0]       r_burst;
  logic             r_ovalid;
  logic [127:0]     r_odata;
  logic [CNT_W-1:0] r_beats1, r_beats2;
  logic             w_adv, w_t1, w_t2, w_xfer, w_last_beat, w_exit;
  logic [127:0]     w_din;
  assign w_adv       = ~r_ovalid | s1o_rdy;
  assign s1i_rdy     = w_adv & (r_state == G1);
  assign s2i_rdy     = w_adv & (r_state == G2);
  assign w_t1        = s1i_valid & s1i_rdy;
  assign w_t2        = s2i_valid & s2i_rdy;
  assign w_xfer      = w_t1 | w_t2;
  assign w_last_beat = w_xfer & (r_burst == 8'(MAX_BURST - 1));
`ifdef STREAM_ARB_TAG_EN
  assign w_din = w_t1 ? {8'h01, s1i_data[119:0]} : {8'h02, s2i_data[119:0]};
`else
  assign w_din = w_t1 ? s1i_data : s2i_data;
`endif
  assign s1o_valid = r_ovalid;
  assign s1o_data  = r_odata;
  assign beats1    = r_beats1;
  assign beats2    = r_beats2;
  // Grant selection: tie in IDLE goes to the source not served last; a grant ends on a full burst or when its source drains
  always_comb begin
    w_next = r_state;
    w_exit = 1'b0;
    case (r_state)
      IDLE: w_next = (s1i_valid & s2i_valid) ? (r_last ? G1 : G2) : s1i_valid ? G1 : s2i_valid ? G2 : IDLE;
      G1: begin
        w_exit = w_last_beat | ~s1i_valid;
        if (w_exit) w_next = s2i_valid ? G2 : IDLE;
      end
      G2: begin
        w_exit = w_last_beat | ~s2i_valid;
        if (w_exit) w_next = s1i_valid ? G1 : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // State, burst tracking, output register and beat counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_burst  <= '0;
      r_ovalid <= 1'b0;
      r_odata  <= '0;
      r_beats1 <= '0;
      r_beats2 <= '0;
    end else begin
      r_state <= w_next;
      if (w_exit) begin
        r_last  <= (r_state == G2);
        r_burst <= '0;
      end else if (w_xfer) r_burst <= r_burst + 8'd1;
      if (w_adv) r_ovalid <= w_xfer;
      if (w_xfer) r_odata <= w_din;
      if (w_t1) r_beats1 <= r_beats1 + CNT_W'(1);
      if (w_t2) r_beats2 <= r_beats2 + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_stream_arb2x128.sv
// tb_stream_arb2x128: directed tests for stream_arb2x128 against a transaction-level arbiter model.
module tb_stream_arb2x128;
  localparam int MB = 4;
  localparam int CW = 4;
  logic clk = 1'b0, rst, s1o_rdy;
  logic s1i_valid, s2i_valid, s1i_rdy, s2i_rdy, s1o_valid;
  logic [127:0] s1i_data, s2i_data, s1o_data;
  logic [CW-1:0] beats1, beats2;
  int n_chk = 0, n_err = 0, cyc = 0;
  logic chk_en = 1'b0;
  logic hs1 = 1'b0, hs2 = 1'b0;
  logic [127:0] q1[$], q2[$], olog[$];
  int ocyc[$];
  stream_arb2x128 #(.MAX_BURST(MB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .s1i_valid(s1i_valid), .s1i_rdy(s1i_rdy), .s1i_data(s1i_data),
    .s2i_valid(s2i_valid), .s2i_rdy(s2i_rdy), .s2i_data(s2i_data),
    .s1o_valid(s1o_valid), .s1o_rdy(s1o_rdy), .s1o_data(s1o_data),
    .beats1(beats1), .beats2(beats2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [127:0] tg(input logic [127:0] d, input int s);
`ifdef STREAM_ARB_TAG_EN
    return {8'(s), d[119:0]};
`else
    return d + 128'(s - s);
`endif
  endfunction
  // Source drivers: present queue heads, pop when a handshake was seen before the edge
  initial begin
    s1i_valid = 1'b0; s2i_valid = 1'b0; s1i_data = '0; s2i_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      if (hs2 && q2.size() > 0) void'(q2.pop_front());
      s1i_valid = q1.size() > 0;
      s1i_data  = q1.size() > 0 ? q1[0] : '0;
      s2i_valid = q2.size() > 0;
      s2i_data  = q2.size() > 0 ? q2[0] : '0;
    end
  end
  always @(negedge clk) begin
    hs1 <= s1i_valid && s1i_rdy && !rst;
    hs2 <= s2i_valid && s2i_rdy && !rst;
    if (s1o_valid && s1o_rdy) begin
      olog.push_back(s1o_data);
      ocyc.push_back(cyc);
    end
  end
  // Reference model: owner of the grant, beats taken in it, who was served last
  int m_own, m_cnt, m_last;
  logic m_ov, m_adv, m_v, m_vo, m_tx;
  logic [127:0] m_od;
  logic [CW-1:0] m_b1, m_b2;
  always_comb begin
    m_adv = !m_ov || s1o_rdy;
    m_v   = m_own == 1 ? s1i_valid : m_own == 2 ? s2i_valid : 1'b0;
    m_vo  = m_own == 1 ? s2i_valid : s1i_valid;
    m_tx  = m_v && m_adv;
  end
  always @(posedge clk) begin
    if (rst) begin
      m_own <= 0; m_cnt <= 0; m_last <= 2; m_ov <= 1'b0; m_od <= '0; m_b1 <= '0; m_b2 <= '0;
    end else begin
      if (m_adv) m_ov <= m_tx;
      if (m_tx) m_od <= tg(m_own == 1 ? s1i_data : s2i_data, m_own);
      if (m_tx && m_own == 1) m_b1 <= m_b1 + 1'b1;
      if (m_tx && m_own == 2) m_b2 <= m_b2 + 1'b1;
      if (m_own == 0) begin
        if (s1i_valid && s2i_valid) m_own <= 3 - m_last;
        else if (s1i_valid) m_own <= 1;
        else if (s2i_valid) m_own <= 2;
      end else if ((m_tx && m_cnt + 1 == MB) || !m_v) begin
        m_own <= m_vo ? 3 - m_own : 0;
        m_last <= m_own;
        m_cnt <= 0;
      end else if (m_tx) m_cnt <= m_cnt + 1;
    end
  end
  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdy1", s1i_rdy, m_adv && m_own == 1);
      chk("rdy2", s2i_rdy, m_adv && m_own == 2);
      chk("ovalid", s1o_valid, m_ov);
      chk("beats1", beats1, m_b1);
      chk("beats2", beats2, m_b2);
      if (m_ov) chk("odata", s1o_data, m_od);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    tick();
    rst = 1'b1;
    q1.delete();
    q2.delete();
    tick();
    rst = 1'b0;
  endtask
  task automatic wait_log(input int n, input string nm);
    for (int i = 0; i < 80 && olog.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    chk(nm, olog.size() >= n, 1'b1);
  endtask
  task automatic drain(input string nm);
    for (int i = 0; i < 100 && (q1.size() > 0 || q2.size() > 0 || s1o_valid); i++) @(negedge clk);
    chk(nm, q1.size() == 0 && q2.size() == 0 && !s1o_valid, 1'b1);
  endtask
  initial begin
    rst = 1'b1;
    s1o_rdy = 1'b1;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ovalid", s1o_valid, 1'b0);
    chk("rst_odata", s1o_data, '0);
    chk("rst_b1", beats1, '0);
    chk("rst_b2", beats2, '0);
    chk("rst_rdy", {s1i_rdy, s2i_rdy}, 2'b00);
    // 1: single source, latency 2, consecutive beats
    do_reset();
    for (int i = 1; i <= 4; i++) q1.push_back(128'(i));
    @(negedge clk);
    chk("t1_lat0", s1o_valid, 1'b0);
    @(negedge clk);
    chk("t1_lat1", s1o_valid, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("t1_valid", s1o_valid, 1'b1);
      chk("t1_data", s1o_data, tg(128'(i), 1));
    end
    @(negedge clk);
    chk("t1_end", s1o_valid, 1'b0);
    chk("t1_b1", beats1, 4'd4);
    chk("t1_b2", beats2, 4'd0);
    // 2: both always valid, bursts of MB alternate without bubbles; S1 count wraps at 16
    do_reset();
    olog.delete(); ocyc.delete();
    for (int i = 0; i < 16; i++) begin
      q1.push_back(128'h100 + 128'(i));
      q2.push_back(128'h200 + 128'(i));
    end
    wait_log(16, "t2_done");
    if (olog.size() >= 16) begin
      chk("t2_b1", beats1, 4'd8);
      chk("t2_b2", beats2, 4'd8);
      chk("t2_nogap", ocyc[15] - ocyc[0], 15);
      for (int k = 0; k < 16; k++) begin
        int g, s, x;
        g = k / 4;
        s = g % 2 == 0 ? 1 : 2;
        x = (g / 2) * 4 + k % 4;
        chk("t2_order", olog[k], tg((s == 1 ? 128'h100 : 128'h200) + 128'(x), s));
      end
    end
    drain("t2_drain");
    chk("t2_wrap", beats1, 4'd0);
    // 3: output backpressure holds the beat and blocks both inputs
    do_reset();
    s1o_rdy = 1'b0;
    q1.push_back(128'hA5); q1.push_back(128'hB6); q2.push_back(128'hC7);
    for (int i = 0; i < 10 && !s1o_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold", s1o_data, tg(128'hA5, 1));
      chk("t3_valid", s1o_valid, 1'b1);
      chk("t3_rdy", {s1i_rdy, s2i_rdy}, 2'b00);
      chk("t3_b1", beats1, 4'd1);
      tick();
      if (i == 4) s1o_rdy = 1'b1;
      @(negedge clk);
    end
    chk("t3_still", s1o_data, tg(128'hA5, 1));
    @(negedge clk);
    chk("t3_next", s1o_data, tg(128'hB6, 1));
    drain("t3_drain");
    // 4: early drain of S1 hands a full burst to S2
    do_reset();
    olog.delete(); ocyc.delete();
    q1.push_back(128'h301); q1.push_back(128'h302);
    for (int i = 1; i <= 8; i++) q2.push_back(128'h400 + 128'(i));
    wait_log(10, "t4_done");
    if (olog.size() >= 10) begin
      chk("t4_s1a", olog[0], tg(128'h301, 1));
      chk("t4_s1b", olog[1], tg(128'h302, 1));
      for (int i = 0; i < 8; i++) chk("t4_s2", olog[2 + i], tg(128'h401 + 128'(i), 2));
      chk("t4_sw_gap", ocyc[2] - ocyc[1], 2);
      chk("t4_burst", ocyc[5] - ocyc[2], 3);
      chk("t4_rot_gap", ocyc[6] - ocyc[5], 2);
    end
    drain("t4_drain");
    // 5: reset in the middle of a G1 burst
    do_reset();
    olog.delete(); ocyc.delete();
    for (int i = 1; i <= 8; i++) begin
      q1.push_back(128'h500 + 128'(i));
      q2.push_back(128'h600 + 128'(i));
    end
    wait_log(1, "t5_start");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ovalid", s1o_valid, 1'b0);
    chk("t5_b", {beats1, beats2}, 8'h00);
    chk("t5_rdy1", s1i_rdy, 1'b0);
    #1;
    olog.delete();
    wait_log(1, "t5_resume");
    if (olog.size() >= 1) chk("t5_s1_first", olog[0], tg(128'h503, 1));
    drain("t5_drain");
    // 6: source tag on S2 data
    do_reset();
    q2.push_back({128{1'b1}});
    for (int i = 0; i < 10 && !s1o_valid; i++) @(negedge clk);
`ifdef STREAM_ARB_TAG_EN
    chk("t6_tag", s1o_data, {8'h02, {120{1'b1}}});
`else
    chk("t6_tag", s1o_data, {128{1'b1}});
`endif
    drain("t6_drain");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
